// File: rtl/serial_addsub.sv
// serial_addsub
//   Digit-serial adder/subtractor. Operands are latched on acceptance, then
//   DIGIT bits per clock are pushed LSB-first through a DIGIT-bit ripple of
//   full adders with a registered carry between digits. The result is
//   assembled in a shift register and published when the last digit is done.
//   Subtraction is A + ~B + ~c_in, so c_out is the raw carry (1 = no borrow).
//
// Parameters
//   WIDTH  operand/result width (>= 2)
//   DIGIT  bits processed per clock (must divide WIDTH)
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready high only in IDLE)
//   a, b, c_in, sub      operands, carry/borrow-in, 0:add 1:subtract
//   out_valid/out_ready  result handshake
//   sum, c_out           registered result and carry out of the MSB
//   ovf                  signed overflow, present only with ADDSUB_OVF_EN
//
// Build option
//   `define ADDSUB_OVF_EN  adds the ovf port and its sign-bit registers.

module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(N + 1);

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_err
      $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;       // B already inverted for subtraction
  logic [WIDTH-1:0]   r_acc;     // result digits enter from the MSB side
  logic               r_carry;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_sum;
  logic               r_c_out;
`ifdef ADDSUB_OVF_EN
  logic               r_a_msb;
  logic               r_b_msb;
  logic               r_ovf;
`endif

  logic [DIGIT-1:0]   w_digit;
  logic [DIGIT:0]     w_chain;
  logic [WIDTH-1:0]   w_acc_next;

  // DIGIT-bit full-adder ripple seeded by the registered carry
  always_comb begin
    w_digit    = '0;
    w_chain    = '0;
    w_chain[0] = r_carry;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      w_digit[i]     = r_a[i] ^ r_b[i] ^ w_chain[i];
      w_chain[i + 1] = (r_a[i] & r_b[i]) | (w_chain[i] & (r_a[i] ^ r_b[i]));
    end
  end

  // Shift the new digit in at the top; written as a shift of the
  // concatenation so DIGIT == WIDTH needs no special case.
  assign w_acc_next = WIDTH'({w_digit, r_acc} >> DIGIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_count     <= '0;
      r_sum       <= '0;
      r_c_out     <= 1'b0;
`ifdef ADDSUB_OVF_EN
      r_a_msb     <= 1'b0;
      r_b_msb     <= 1'b0;
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= sub ? ~b : b;
            r_carry    <= sub ^ c_in;
            r_count    <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
`ifdef ADDSUB_OVF_EN
            r_a_msb    <= a[WIDTH-1];
            r_b_msb    <= sub ^ b[WIDTH-1];
`endif
          end
        end
        S_RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_acc   <= w_acc_next;
          r_carry <= w_chain[DIGIT];
          r_count <= r_count + 1'b1;
          if (r_count == CNT_W'(N - 1)) begin
            r_sum       <= w_acc_next;
            r_c_out     <= w_chain[DIGIT];
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
`ifdef ADDSUB_OVF_EN
            r_ovf       <= (r_a_msb == r_b_msb) && (w_acc_next[WIDTH-1] != r_a_msb);
`endif
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign c_out     = r_c_out;
`ifdef ADDSUB_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule
